// File: rtl/i2s_codec_emu.sv
// I2S slave codec emulator: deserializes the master's data stream into stereo pairs
// and serializes locally supplied pairs back, all from an oversampling clock.
module i2s_codec_emu #(
    parameter int DATA_W = 24,
    parameter int SLOT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lrck_i,
    input  logic              sclk_i,
    input  logic              sd_i,
    output logic              sd_o,
    output logic [DATA_W-1:0] rx_l,
    output logic [DATA_W-1:0] rx_r,
    output logic              rx_vld,
    input  logic [DATA_W-1:0] tx_l,
    input  logic [DATA_W-1:0] tx_r,
    input  logic              tx_vld,
    output logic              tx_urun,
    output logic              frame_err
);
    localparam int CNT_W = $clog2(SLOT_W + 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    // Synchronizer stages hold {lrck, sclk, sd}
    logic [2:0]        sync_m_q, sync_m_d, sync_s_q, sync_s_d;
    logic              sclk_prev_q, sclk_prev_d;
    state_t            state_q, state_d;
    logic              lr_q, lr_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] l_hold_q, l_hold_d;
    logic              l_vld_q, l_vld_d;
    logic [DATA_W-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
    logic              rx_vld_q, rx_vld_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic              new_flag_q, new_flag_d;
    logic [DATA_W-1:0] cur_l_q, cur_l_d, cur_r_q, cur_r_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic              sd_o_q, sd_o_d;
    logic              tx_urun_q, tx_urun_d;
    logic              frame_err_q, frame_err_d;

    logic              lrck_s, sclk_s, sd_s, rise, fall;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] tx_sel;

    always_comb begin
        sync_m_d    = {lrck_i, sclk_i, sd_i};
        sync_s_d    = sync_m_q;
        lrck_s      = sync_s_q[2];
        sclk_s      = sync_s_q[1];
        sd_s        = sync_s_q[0];
        sclk_prev_d = sclk_s;
        rise        = sclk_s & ~sclk_prev_q;
        fall        = ~sclk_s & sclk_prev_q;
        cnt_inc     = (bit_cnt_q == CNT_W'(SLOT_W)) ? bit_cnt_q : bit_cnt_q + 1'b1;
        tx_sel      = lr_q ? cur_r_q : cur_l_q;

        state_d     = state_q;
        lr_d        = lr_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        l_hold_d    = l_hold_q;
        l_vld_d     = l_vld_q;
        rx_l_d      = rx_l_q;
        rx_r_d      = rx_r_q;
        rx_vld_d    = 1'b0;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        new_flag_d  = new_flag_q;
        cur_l_d     = cur_l_q;
        cur_r_d     = cur_r_q;
        tx_sr_d     = tx_sr_q;
        sd_o_d      = sd_o_q;
        tx_urun_d   = 1'b0;
        frame_err_d = 1'b0;

        if (tx_vld) begin
            hold_l_d   = tx_l;
            hold_r_d   = tx_r;
            new_flag_d = 1'b1;
        end

        if (rise) begin
            if (lrck_s != lr_q) begin
                bit_cnt_d = '0;
                lr_d      = lrck_s;
                if (state_q == UNLOCKED) begin
                    state_d = LOCKED;
                end else begin
                    // A short slot never set l_vld (left) or never reached the right
                    // capture point, so the word is dropped without extra bookkeeping.
                    frame_err_d = (bit_cnt_q < CNT_W'(DATA_W));
                    if (!lrck_s) begin
                        l_vld_d    = 1'b0;
                        new_flag_d = 1'b0;
                        tx_urun_d  = ~new_flag_q & ~tx_vld;
                        cur_l_d    = tx_vld ? tx_l : hold_l_q;
                        cur_r_d    = tx_vld ? tx_r : hold_r_q;
                    end
                end
            end else begin
                bit_cnt_d = cnt_inc;
                if (state_q == LOCKED && cnt_inc <= CNT_W'(DATA_W)) begin
                    rx_sr_d = {rx_sr_q[DATA_W-3:0], sd_s};
                    if (cnt_inc == CNT_W'(DATA_W)) begin
                        if (!lr_q) begin
                            l_hold_d = {rx_sr_q, sd_s};
                            l_vld_d  = 1'b1;
                        end else begin
                            if (l_vld_q) begin
                                rx_l_d   = l_hold_q;
                                rx_r_d   = {rx_sr_q, sd_s};
                                rx_vld_d = 1'b1;
                            end
                            l_vld_d = 1'b0;
                        end
                    end
                end
            end
        end

        // Zeros shift in behind the word, so sd_o idles low once DATA_W bits are out
        if (fall && state_q == LOCKED) begin
            if (bit_cnt_q == '0) begin
                sd_o_d  = tx_sel[DATA_W-1];
                tx_sr_d = tx_sel << 1;
            end else begin
                sd_o_d  = tx_sr_q[DATA_W-1];
                tx_sr_d = tx_sr_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_m_q    <= '0;
            sync_s_q    <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= UNLOCKED;
            lr_q        <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            l_hold_q    <= '0;
            l_vld_q     <= 1'b0;
            rx_l_q      <= '0;
            rx_r_q      <= '0;
            rx_vld_q    <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            new_flag_q  <= 1'b0;
            cur_l_q     <= '0;
            cur_r_q     <= '0;
            tx_sr_q     <= '0;
            sd_o_q      <= 1'b0;
            tx_urun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_m_q    <= sync_m_d;
            sync_s_q    <= sync_s_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            lr_q        <= lr_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            l_hold_q    <= l_hold_d;
            l_vld_q     <= l_vld_d;
            rx_l_q      <= rx_l_d;
            rx_r_q      <= rx_r_d;
            rx_vld_q    <= rx_vld_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            new_flag_q  <= new_flag_d;
            cur_l_q     <= cur_l_d;
            cur_r_q     <= cur_r_d;
            tx_sr_q     <= tx_sr_d;
            sd_o_q      <= sd_o_d;
            tx_urun_q   <= tx_urun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign sd_o      = sd_o_q;
    assign rx_l      = rx_l_q;
    assign rx_r      = rx_r_q;
    assign rx_vld    = rx_vld_q;
    assign tx_urun   = tx_urun_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_i2s_codec_emu.sv
// Bench for i2s_codec_emu: an I2S master drives frames from a directed table and from
// random draws; a frame-level model of the codec supplies every expected value.
module tb_i2s_codec_emu;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        lrck = 1'b0, sclk = 1'b0, sd = 1'b0;
    logic        tx_vld = 1'b0;
    logic [23:0] tx_l = '0, tx_r = '0;
    logic        sd_o, rx_vld, tx_urun, frame_err;
    logic [23:0] rx_l, rx_r;

    always #5 clk = ~clk;

    i2s_codec_emu #(.DATA_W(24), .SLOT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .lrck_i(lrck), .sclk_i(sclk), .sd_i(sd),
        .sd_o(sd_o), .rx_l(rx_l), .rx_r(rx_r), .rx_vld(rx_vld),
        .tx_l(tx_l), .tx_r(tx_r), .tx_vld(tx_vld),
        .tx_urun(tx_urun), .frame_err(frame_err)
    );

    int errors = 0, checks = 0;
    int rx_cnt = 0, urun_cnt = 0, ferr_cnt = 0;
    logic [23:0] last_rx_l = '0, last_rx_r = '0;

    // Pulse counting: a pulse held for two cycles counts twice and is caught
    always @(negedge clk) begin
        if (rx_vld) begin
            rx_cnt++;
            last_rx_l = rx_l;
            last_rx_r = rx_r;
        end
        if (tx_urun)   urun_cnt++;
        if (frame_err) ferr_cnt++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Frame-level model of the codec as seen from the master
    bit          m_lr, m_locked, m_lvalid, m_pend;
    logic [23:0] m_cur_l, m_cur_r, m_hold_l, m_hold_r;
    int          m_prev_rbits;

    task automatic m_reset();
        m_lr = 0; m_locked = 0; m_lvalid = 0; m_pend = 0;
        m_cur_l = '0; m_cur_r = '0; m_hold_l = '0; m_hold_r = '0;
        m_prev_rbits = 32;
    endtask

    typedef struct {
        logic [23:0] lw, rw;
        int          lbits, rbits;
        int          post;      // 0 none, 1 with left-slot start, 2 mid right slot
        logic [23:0] txl, txr;
        int          rst_at;    // left-slot bit period at which reset pulses, -1 none
        int          exp_rx, exp_urun, exp_ferr;
    } vec_t;

    task automatic rise_half(input bit do_post, input logic [23:0] pl, input logic [23:0] pr);
        sclk = 1'b1;
        if (do_post) begin
            #20; tx_l = pl; tx_r = pr; tx_vld = 1'b1;
            #10; tx_vld = 1'b0;
            #30;
        end else begin
            #60;
        end
    endtask

    task automatic run_slot(input bit lr, input logic [23:0] w, input int n, input int post_at,
                            input logic [23:0] pl, input logic [23:0] pr, input int rst_at,
                            input logic [23:0] tw, output logic [31:0] got, output logic [31:0] exp);
        got = '0;
        exp = '0;
        for (int j = 0; j < n; j++) begin
            sclk = 1'b0;
            lrck = lr;
            if (j >= 1 && j <= 24) sd = w[24-j];
            else                   sd = 1'b0;
            if (j == rst_at) begin
                #10; rst_n = 1'b0;
                #20;
                check("reset_outputs", {sd_o, rx_vld, tx_urun, frame_err, rx_l, rx_r}, 64'd0);
                rst_n = 1'b1;
                m_reset();
                #30;
            end else begin
                #60;
            end
            if (j >= 1 && j < 32) begin
                got[j] = sd_o;
                if (m_locked && j <= 24) exp[j] = tw[24-j];
            end
            rise_half(j == post_at, pl, pr);
        end
    endtask

    task automatic do_frame(input int idx, input vec_t v, input bit use_tab);
        int r0, u0, f0, e_rx, e_u, e_f;
        logic [31:0] gl, el, gr, er;
        r0 = rx_cnt; u0 = urun_cnt; f0 = ferr_cnt;
        e_rx = 0; e_u = 0; e_f = 0;
        if (m_lr && m_locked) begin
            if (m_prev_rbits < 25) e_f++;
            if (v.post == 1) begin
                m_cur_l = v.txl; m_cur_r = v.txr; m_hold_l = v.txl; m_hold_r = v.txr; m_pend = 0;
            end else if (m_pend) begin
                m_cur_l = m_hold_l; m_cur_r = m_hold_r; m_pend = 0;
            end else begin
                e_u = 1;
            end
            m_lvalid = (v.lbits >= 25);
        end else if (v.post == 1) begin
            m_hold_l = v.txl; m_hold_r = v.txr; m_pend = 1;
        end
        m_lr = 0;
        run_slot(1'b0, v.lw, v.lbits, (v.post == 1) ? 0 : -1, v.txl, v.txr, v.rst_at, m_cur_l, gl, el);
        if (m_locked) begin
            if (v.lbits < 25) e_f++;
            if (m_lvalid && v.rbits >= 25) e_rx = 1;
        end else begin
            m_locked = 1;
        end
        m_lvalid = 0;
        m_lr = 1;
        run_slot(1'b1, v.rw, v.rbits, (v.post == 2) ? 5 : -1, v.txl, v.txr, -1, m_cur_r, gr, er);
        if (v.post == 2) begin
            m_hold_l = v.txl; m_hold_r = v.txr; m_pend = 1;
        end
        m_prev_rbits = v.rbits;
        if (use_tab) begin
            e_rx = v.exp_rx; e_u = v.exp_urun; e_f = v.exp_ferr;
        end
        check("frame_err", 64'(ferr_cnt - f0), 64'(e_f));
        check("tx_urun", 64'(urun_cnt - u0), 64'(e_u));
        check("rx_vld", 64'(rx_cnt - r0), 64'(e_rx));
        if (e_rx == 1 && rx_cnt - r0 == 1)
            check("rx_pair", {16'd0, last_rx_l, last_rx_r}, {16'd0, v.lw, v.rw});
        check("sd_o_left", 64'(gl), 64'(el));
        check("sd_o_right", 64'(gr), 64'(er));
        $display("frame %0d L=%06h R=%06h bits=%0d/%0d post=%0d rx=%0d urun=%0d ferr=%0d",
                 idx, v.lw, v.rw, v.lbits, v.rbits, v.post, rx_cnt - r0, urun_cnt - u0, ferr_cnt - f0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tab[10];
    vec_t v;

    initial begin
        tab[0] = '{24'hA5A5A5, 24'h123456, 32, 32, 2, 24'h800001, 24'h7FFFFE, -1, 0, 0, 0};
        tab[1] = '{24'hA5A5A5, 24'h123456, 32, 32, 0, 24'h000000, 24'h000000, -1, 1, 0, 0};
        tab[2] = '{24'hA5A5A5, 24'h123456, 32, 32, 0, 24'h000000, 24'h000000, -1, 1, 1, 0};
        tab[3] = '{24'h111111, 24'h222222, 16, 32, 0, 24'h000000, 24'h000000, -1, 0, 1, 1};
        tab[4] = '{24'hABCDEF, 24'hFEDCBA, 32, 32, 1, 24'hC0FFEE, 24'h0BEEF1, -1, 1, 0, 0};
        tab[5] = '{24'h135790, 24'h24680A, 32, 32, 0, 24'h000000, 24'h000000, 10, 0, 1, 0};
        tab[6] = '{24'h0F0F0F, 24'hF0F0F0, 32, 32, 0, 24'h000000, 24'h000000, -1, 1, 1, 0};
        tab[7] = '{24'h00000F, 24'hFFFFF0, 32, 20, 2, 24'h5A5A5A, 24'hA5A5A5, -1, 0, 1, 0};
        tab[8] = '{24'h654321, 24'h765432, 32, 32, 0, 24'h000000, 24'h000000, -1, 1, 0, 1};
        tab[9] = '{24'hAAAAAA, 24'h555555, 25, 25, 0, 24'h000000, 24'h000000, -1, 1, 1, 0};

        m_reset();
        repeat (4) @(posedge clk);
        #3;
        check("reset_state", {sd_o, rx_vld, tx_urun, frame_err, rx_l, rx_r}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) do_frame(i, tab[i], 1'b1);

        for (int i = 0; i < 16; i++) begin
            v.lw    = 24'($urandom);
            v.rw    = 24'($urandom);
            v.lbits = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 24) : $urandom_range(25, 32);
            v.rbits = ($urandom_range(0, 5) == 0) ? $urandom_range(10, 24) : $urandom_range(25, 32);
            v.post  = $urandom_range(0, 2);
            v.txl   = 24'($urandom);
            v.txr   = 24'($urandom);
            v.rst_at = -1;
            v.exp_rx = 0; v.exp_urun = 0; v.exp_ferr = 0;
            do_frame(10 + i, v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
